// File: rtl/spike_input_scheduler.sv
// spike_input_scheduler
//   Runs one image presentation on the bernoulli spike generator. It takes
//   NUM_SPIKES 8-bit pixels over a valid/ready stream and writes each one as a
//   rate word into generator memory. It then holds the generator enabled for
//   2*num_steps clocks while counting the emitted spikes, and pulses done at
//   the end. This block is the only master of the generator mem/en ports.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin presentation (IDLE only) / cancel to IDLE
//   num_steps           timesteps to run, latched on an accepted start
//   pix_valid/ready/data  pixel stream (8-bit intensity)
//   gen_addr/wen/wdata  generator rate-memory write port
//   gen_en              generator enable
//   gen_spikes          spike vector from generator (combinational there)
//   busy, done          status; done is a 1-cycle pulse on normal completion
//   spike_count         saturating spike total of the last/current run
module spike_input_scheduler #(
    parameter int NUM_SPIKES = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STEP_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [STEP_WIDTH-1:0] num_steps,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [7:0]            pix_data,
    output logic [ADDR_WIDTH-1:0] gen_addr,
    output logic                  gen_wen,
    output logic [DATA_WIDTH-1:0] gen_wdata,
    output logic                  gen_en,
    input  logic [NUM_SPIKES-1:0] gen_spikes,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  spike_count
);

    localparam int IDX_W = $clog2(NUM_SPIKES + 1);
    localparam int PC_W  = $clog2(NUM_SPIKES + 1);
    localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      pix_idx;
    logic [STEP_WIDTH-1:0] steps_q;
    logic [STEP_WIDTH:0]   run_cnt;
    logic [STEP_WIDTH:0]   run_last;
    logic [PC_W-1:0]       spike_pc;
    logic [CNT_WIDTH:0]    cnt_sum;
    logic                  pix_hs;

    assign pix_hs = pix_valid && pix_ready;

    // One timestep is two clocks; the extra bit lets num_steps reach its max.
    // Only used in RUN, where steps_q is known to be non-zero.
    assign run_last = {steps_q, 1'b0} - (STEP_WIDTH + 1)'(1);

    always_comb begin
        spike_pc = '0;
        for (int i = 0; i < NUM_SPIKES; i++)
            spike_pc = spike_pc + PC_W'(gen_spikes[i]);
    end

    assign cnt_sum = {1'b0, spike_count} + (CNT_WIDTH + 1)'(spike_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pix_ready   <= 1'b0;
            gen_wen     <= 1'b0;
            gen_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            gen_addr    <= '0;
            gen_wdata   <= '0;
            spike_count <= '0;
            pix_idx     <= '0;
            steps_q     <= '0;
            run_cnt     <= '0;
        end else begin
            gen_wen <= 1'b0;
            done    <= 1'b0;

            // Counting follows the registered enable, so the cycle an abort
            // lands in is still counted: the generator was enabled then.
            if (gen_en)
                spike_count <= (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}}
                                                   : cnt_sum[CNT_WIDTH-1:0];

            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                pix_ready <= 1'b0;
                gen_en    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state       <= LOAD;
                            busy        <= 1'b1;
                            pix_ready   <= 1'b1;
                            steps_q     <= num_steps;
                            spike_count <= '0;
                            pix_idx     <= '0;
                            run_cnt     <= '0;
                        end
                    end
                    LOAD: begin
                        if (pix_hs) begin
                            gen_wen   <= 1'b1;
                            gen_addr  <= ADDR_WIDTH'(pix_idx);
                            gen_wdata <= DATA_WIDTH'(pix_data) << (DATA_WIDTH - 9);
                            pix_idx   <= pix_idx + 1'b1;
                            if (pix_idx == IDX_W'(NUM_SPIKES - 1))
                                pix_ready <= 1'b0;
                        end else if (pix_idx == IDX_W'(NUM_SPIKES)) begin
                            // Last write is on the bus this cycle; enable follows it.
                            if (steps_q == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state   <= RUN;
                                gen_en  <= 1'b1;
                                run_cnt <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (run_cnt == run_last) begin
                            gen_en <= 1'b0;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_input_scheduler.sv
// Directed bench for spike_input_scheduler (CNT_WIDTH=8 so saturation is reachable).
module tb_spike_input_scheduler;

    localparam int NS = 32;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [7:0]    pix_data = '0;
    logic [AW-1:0] gen_addr;
    logic          gen_wen;
    logic [DW-1:0] gen_wdata;
    logic          gen_en;
    logic [NS-1:0] gen_spikes = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] spike_count;

    spike_input_scheduler #(
        .NUM_SPIKES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STEP_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .gen_addr(gen_addr), .gen_wen(gen_wen), .gen_wdata(gen_wdata),
        .gen_en(gen_en), .gen_spikes(gen_spikes), .busy(busy), .done(done),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // monitor state (written only by the monitor)
    int cyc = 0, wr_cnt = 0, en_cnt = 0, done_cnt = 0, early_cnt = 0;
    int last_wen_cyc = -1, en_rise_cyc = -1, last_en_cyc = -1, done_cyc = -1;
    int mk;
    logic prev_en = 1'b0;
    logic [AW-1:0] wa [32];
    logic [DW-1:0] wd [32];

    // snapshots (written only by the stimulus process)
    int wr_base = 0, en0 = 0, done0 = 0, early0 = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (gen_wen) begin
            mk = wr_cnt - wr_base;
            if (mk >= 0 && mk < 32) begin
                wa[mk] = gen_addr;
                wd[mk] = gen_wdata;
            end
            wr_cnt = wr_cnt + 1;
            last_wen_cyc = cyc;
        end
        if (gen_en) begin
            en_cnt = en_cnt + 1;
            last_en_cyc = cyc;
            if (!prev_en) en_rise_cyc = cyc;
            if (wr_cnt - wr_base < 32) early_cnt = early_cnt + 1;
        end
        prev_en = gen_en;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        wr_base = wr_cnt;
        en0     = en_cnt;
        done0   = done_cnt;
        early0  = early_cnt;
    endtask

    task automatic do_start(input int n);
        num_steps = SW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input int gap);
        logic hs;
        logic ok;
        ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            hs = pix_ready;
            tick();
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("hs_timeout", 64'd0, 64'd1);
        pix_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // mode 0: all 255, mode 1: all 0, mode 2: i*7+3 with random gaps
    function automatic logic [7:0] pix_val(input int mode, input int i);
        if (mode == 0) return 8'hFF;
        if (mode == 1) return 8'h00;
        return 8'(i * 7 + 3);
    endfunction

    task automatic load(input int n, input int mode);
        for (int i = 0; i < n; i++)
            send_pixel(pix_val(mode, i), (mode == 2) ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic check_writes(input string tag, input int mode);
        int bad;
        logic [DW-1:0] expv;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            expv = {1'b0, pix_val(mode, i), 23'h0};
            if (wa[i] !== AW'(i) || wd[i] !== expv) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int bound);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(tag, 64'd0, 64'd1);
        tick();
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        tick();
    endtask

    task automatic wait_en(input string tag);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (gen_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(tag, 64'd0, 64'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("reset_flags", {59'd0, pix_ready, gen_wen, gen_en, busy, done}, 64'd0);
        chk("reset_addr", 64'(gen_addr), 64'd0);
        chk("reset_wdata", 64'(gen_wdata), 64'd0);
        chk("reset_cnt", 64'(spike_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // start together with abort is ignored; abort alone in IDLE is harmless
        start = 1'b1; abort = 1'b1; num_steps = 16'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", {62'd0, busy, pix_ready}, 64'd0);
        tick();

        // T1: 255 pixels back-to-back, 10 steps, 2 spikes per enabled cycle
        begin_test();
        gen_spikes = 32'h0000_0003;
        do_start(10);
        @(negedge clk);
        chk("t1_busy_ready", {62'd0, busy, pix_ready}, 64'd3);
        tick();
        load(32, 0);
        @(negedge clk);
        chk("t1_ready_drop", {63'd0, pix_ready}, 64'd0);
        tick();
        wait_done("t1_done", 100);
        chk("t1_writes", 64'(wr_cnt - wr_base), 64'd32);
        check_writes("t1_addr_data", 0);
        chk("t1_en_cycles", 64'(en_cnt - en0), 64'd20);
        chk("t1_en_after_wen", 64'(en_rise_cyc), 64'(last_wen_cyc + 1));
        chk("t1_done_after_en", 64'(done_cyc), 64'(last_en_cyc + 1));
        chk("t1_done_once", 64'(done_cnt - done0), 64'd1);
        chk("t1_spike_count", 64'(spike_count), 64'd40);

        // T2: zero pixels, 50 steps, no spikes
        begin_test();
        gen_spikes = '0;
        do_start(50);
        load(32, 1);
        wait_done("t2_done", 200);
        check_writes("t2_addr_data", 1);
        chk("t2_en_cycles", 64'(en_cnt - en0), 64'd100);
        chk("t2_spike_count", 64'(spike_count), 64'd0);
        chk("t2_done_once", 64'(done_cnt - done0), 64'd1);

        // T3: gapped stream, distinct data, 2 steps, 1 spike per enabled cycle
        begin_test();
        gen_spikes = 32'h0000_0001;
        do_start(2);
        load(32, 2);
        wait_done("t3_done", 50);
        chk("t3_writes", 64'(wr_cnt - wr_base), 64'd32);
        check_writes("t3_addr_data", 2);
        chk("t3_no_early_en", 64'(early_cnt - early0), 64'd0);
        chk("t3_en_after_wen", 64'(en_rise_cyc), 64'(last_wen_cyc + 1));
        chk("t3_spike_count", 64'(spike_count), 64'd4);

        // T4: zero steps -> straight to done, generator never enabled
        begin_test();
        gen_spikes = '1;
        do_start(0);
        load(32, 0);
        wait_done("t4_done", 20);
        chk("t4_writes", 64'(wr_cnt - wr_base), 64'd32);
        chk("t4_en_cycles", 64'(en_cnt - en0), 64'd0);
        chk("t4_done_after_wen", 64'(done_cyc), 64'(last_wen_cyc + 1));
        chk("t4_spike_count", 64'(spike_count), 64'd0);

        // T5a: abort after 5 pixels
        begin_test();
        gen_spikes = 32'h0000_0001;
        do_start(10);
        load(5, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t5a_idle", {60'd0, busy, pix_ready, gen_en, gen_wen}, 64'd0);
        tick();
        repeat (10) tick();
        chk("t5a_writes", 64'(wr_cnt - wr_base), 64'd5);
        chk("t5a_no_done", 64'(done_cnt - done0), 64'd0);

        // T5b: abort during RUN after 7 enabled cycles, 2 spikes each
        begin_test();
        gen_spikes = 32'h0000_0005;
        do_start(10);
        load(32, 0);
        wait_en("t5b_en_timeout");
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t5b_idle", {62'd0, busy, gen_en}, 64'd0);
        tick();
        repeat (5) tick();
        chk("t5b_no_done", 64'(done_cnt - done0), 64'd0);
        chk("t5b_en_cycles", 64'(en_cnt - en0), 64'd7);
        chk("t5b_partial_cnt", 64'(spike_count), 64'd14);

        // T5c: normal run afterwards restarts at address 0
        begin_test();
        gen_spikes = '0;
        do_start(1);
        load(32, 2);
        wait_done("t5c_done", 20);
        check_writes("t5c_addr_data", 2);
        chk("t5c_en_cycles", 64'(en_cnt - en0), 64'd2);
        chk("t5c_done_once", 64'(done_cnt - done0), 64'd1);

        // T6a: start during RUN ignored; 10 cycles x 32 spikes saturates at 255
        begin_test();
        gen_spikes = '1;
        do_start(5);
        load(32, 0);
        wait_en("t6a_en_timeout");
        num_steps = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6a_done", 100);
        chk("t6a_en_cycles", 64'(en_cnt - en0), 64'd10);
        chk("t6a_done_once", 64'(done_cnt - done0), 64'd1);
        chk("t6a_saturate", 64'(spike_count), 64'd255);

        // T6b: async reset mid-RUN clears outputs without a clock edge
        begin_test();
        gen_spikes = 32'h0000_0001;
        do_start(5);
        load(32, 0);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6b_rst_flags", {59'd0, pix_ready, gen_wen, gen_en, busy, done}, 64'd0);
        chk("t6b_rst_cnt", 64'(spike_count), 64'd0);
        chk("t6b_rst_addr", 64'(gen_addr), 64'd0);
        chk("t6b_rst_wdata", 64'(gen_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
